// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw buttons in, debounced levels, press pulses and
// the stretched reset out. The master drives btn; the slave (btn_debounce) drives the rest.
interface btn_debounce_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_out;
    logic [N_BTN-1:0] btn_press;
    logic             reset_out;

    modport master (
        output btn,
        input  btn_out,
        input  btn_press,
        input  reset_out
    );

    modport slave (
        input  btn,
        output btn_out,
        output btn_press,
        output reset_out
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: input conditioning in front of the graphic core.
// Per button: 2-FF synchroniser, 4-state debounce FSM, registered level and a
// one-cycle press pulse. reset_out is i_reset stretched by RST_HOLD cycles.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN
// (requires REPEAT_RATE <= REPEAT_DELAY).
module btn_debounce #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned DB_CYCLES    = 500000,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    btn_debounce_if.slave bus
);
    localparam int unsigned HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StRelWait
    } state_e;

    logic [N_BTN-1:0]  r_s1;
    logic [N_BTN-1:0]  r_s2;
    logic              r_rst_out;
    logic [HOLD_W-1:0] r_hold;

    // Two-stage synchroniser for the asynchronous button pins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.btn;
            r_s2 <= r_s1;
        end
    end

    // Reset stretcher: held high during reset, then RST_HOLD more cycles
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rst_out <= 1'b1;
            r_hold    <= '0;
        end else if (r_rst_out) begin
            if (r_hold == HOLD_W'(RST_HOLD)) begin
                r_rst_out <= 1'b0;
            end else begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end
    end

    assign bus.reset_out = r_rst_out;

`ifdef BTN_REPEAT_EN
    localparam int unsigned REP_W = CNT_W + 6;
    localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY);
    // After each repeat pulse r is pulled back so it hits REP_FIRST again in REPEAT_RATE cycles
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);
`else
    logic w_unused_repeat;
    assign w_unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        state_e           r_state;
        state_e           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_out;
        logic             r_press;
        logic             w_press_nxt;
`ifdef BTN_REPEAT_EN
        logic [REP_W-1:0] r_rep;
        logic [REP_W-1:0] w_rep_nxt;
        logic [REP_W-1:0] w_rep_inc;
        assign w_rep_inc = r_rep + REP_W'(1);
`endif

        // State, counter and registered outputs
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_state <= StIdle;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_press <= 1'b0;
`ifdef BTN_REPEAT_EN
                r_rep   <= '0;
`endif
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= (w_state_nxt == StHeld) || (w_state_nxt == StRelWait);
                r_press <= w_press_nxt;
`ifdef BTN_REPEAT_EN
                r_rep   <= w_rep_nxt;
`endif
            end
        end

        // Debounce next-state: a level change needs DB_CYCLES stable samples
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_press_nxt = 1'b0;
`ifdef BTN_REPEAT_EN
            w_rep_nxt   = r_rep;
`endif
            unique case (r_state)
                StIdle: begin
                    if (r_s2[g]) begin
                        w_state_nxt = StPressWait;
                        w_cnt_nxt   = '0;
                    end
                end
                StPressWait: begin
                    if (!r_s2[g]) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt = StHeld;
                        w_cnt_nxt   = '0;
                        w_press_nxt = 1'b1;
`ifdef BTN_REPEAT_EN
                        w_rep_nxt   = '0;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                StHeld: begin
                    if (!r_s2[g]) begin
                        w_state_nxt = StRelWait;
                        w_cnt_nxt   = '0;
                    end
`ifdef BTN_REPEAT_EN
                    else if (w_rep_inc == REP_FIRST) begin
                        w_press_nxt = 1'b1;
                        w_rep_nxt   = REP_RELOAD;
                    end else begin
                        w_rep_nxt = w_rep_inc;
                    end
`endif
                end
                StRelWait: begin
                    if (r_s2[g]) begin
                        // Release glitch: back to held, repeat timer resumes where it froze
                        w_state_nxt = StHeld;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
`ifdef BTN_REPEAT_EN
                        w_rep_nxt   = '0;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end

        assign bus.btn_out[g]   = r_out;
        assign bus.btn_press[g] = r_press;
    end
endmodule
